// File: rtl/data_memory_pkg.sv
// Shared widths and data types for the MEM-stage data memory.
package data_memory_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/data_memory.sv
// Byte-addressed big-endian data memory with byte/word writes and combinational word read.
// Optional macro DMEM_RESET_CLEAR_EN: reset clears the array (otherwise contents untouched).
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enableBW,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [BYTE_W-1:0] writeByte,
  input  logic [DATA_W-1:0] writeWord,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] readData
);
  localparam int IDX_W = $clog2(DEPTH);

  byte_t            mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             wr_hi;
  logic             wr_lo;
  byte_t            hi_data;

  // Upper address bits are dropped; the second byte of a word wraps modulo DEPTH.
  assign idx     = address[IDX_W-1:0];
  assign idx_nxt = idx + IDX_W'(1);

  // Byte writes only touch the addressed lane; word writes touch both.
  assign wr_hi   = memWrite;
  assign wr_lo   = memWrite & ~wr_enableBW;
  assign hi_data = wr_enableBW ? writeByte : writeWord[DATA_W-1:BYTE_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef DMEM_RESET_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`endif
    end else begin
      if (wr_hi) mem[idx]     <= hi_data;
      if (wr_lo) mem[idx_nxt] <= writeWord[BYTE_W-1:0];
    end
  end

  assign readData = memRead ? {mem[idx], mem[idx_nxt]} : '0;
endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; reset checks follow DMEM_RESET_CLEAR_EN.
module tb_data_memory;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_enableBW;
  logic        memRead;
  logic        memWrite;
  logic [7:0]  writeByte;
  logic [15:0] writeWord;
  logic [15:0] address;
  logic [15:0] readData;

  int n_assert = 0;
  int n_fail   = 0;

  data_memory dut (
    .clk(clk), .rst(rst), .wr_enableBW(wr_enableBW), .memRead(memRead),
    .memWrite(memWrite), .writeByte(writeByte), .writeWord(writeWord),
    .address(address), .readData(readData)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    memWrite = 1'b0; memRead = 1'b1; address = a;
    #1;
    chk(tag, readData, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic bw, input logic [7:0] b, input logic [15:0] w);
    memWrite = 1'b1; wr_enableBW = bw; address = a; writeByte = b; writeWord = w;
    tick;
    memWrite = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_enableBW = 1'b0; memRead = 1'b1; memWrite = 1'b0;
    writeByte = 8'h00; writeWord = 16'h0000; address = 16'h0000;
    tick;
`ifdef DMEM_RESET_CLEAR_EN
    rd(16'h0000, 16'h0000, "reset_a0");
    rd(16'h0080, 16'h0000, "reset_a80");
`endif
    rst = 1'b1;

    wr(16'h0000, 1'b0, 8'h00, 16'hAB10);
    rd(16'h0000, 16'hAB10, "word_write");

    memRead = 1'b0; address = 16'h0000; #1;
    chk("gate_a0", readData, 16'h0000);
    address = 16'h0001; #1;
    chk("gate_a1", readData, 16'h0000);

    memWrite = 1'b0; writeWord = 16'hCC10; writeByte = 8'hEE; address = 16'h0000;
    tick; tick;
    rd(16'h0000, 16'hAB10, "nowrite_hold");

    wr(16'h0002, 1'b0, 8'h00, 16'h7788);
    rd(16'h0002, 16'h7788, "word_a2");

    wr(16'h0001, 1'b1, 8'hCC, 16'hFFFF);
    rd(16'h0000, 16'hABCC, "byte_a0");
    rd(16'h0001, 16'hCC77, "byte_a1_misalign");
    rd(16'h0002, 16'h7788, "byte_no_lo_lane");

    wr(16'h00FF, 1'b0, 8'h00, 16'h1234);
    rd(16'h00FF, 16'h1234, "wrap_ff");
    rd(16'h0000, 16'h34CC, "wrap_a0");
    rd(16'h01FF, 16'h1234, "upper_addr_ignored");

    wr(16'h00FF, 1'b1, 8'h99, 16'h0000);
    rd(16'h00FF, 16'h9934, "byte_ff_no_wrap_write");

    wr(16'h0010, 1'b0, 8'h00, 16'hAB10);
    memRead = 1'b1; memWrite = 1'b1; wr_enableBW = 1'b0;
    writeWord = 16'h5A5A; address = 16'h0010; #1;
    chk("rdw_before", readData, 16'hAB10);
    tick;
    chk("rdw_after", readData, 16'h5A5A);
    memWrite = 1'b0;

    rst = 1'b0; memWrite = 1'b1; wr_enableBW = 1'b0;
    writeWord = 16'hBEEF; address = 16'h0010;
    tick;
    rst = 1'b1; memWrite = 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
    rd(16'h0010, 16'h0000, "rst_prio_cleared");
    rd(16'h00FF, 16'h0000, "rst_clear_ff");
`else
    rd(16'h0010, 16'h5A5A, "rst_prio_nowrite");
    rd(16'h00FF, 16'h9934, "rst_keeps_ff");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
